// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, port ids,
// output-register FSM encoding and the ALU result bundle.
package alu_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned DATA_W = 8;

    // ALU opcodes
    localparam logic [OPC_W-1:0] ADD   = 4'd0;
    localparam logic [OPC_W-1:0] SUB   = 4'd1;
    localparam logic [OPC_W-1:0] AND   = 4'd2;
    localparam logic [OPC_W-1:0] OR    = 4'd3;
    localparam logic [OPC_W-1:0] XOR   = 4'd4;
    localparam logic [OPC_W-1:0] SLT   = 4'd5;
    localparam logic [OPC_W-1:0] SHIFT = 4'd6;
    localparam logic [OPC_W-1:0] ADDI  = 4'd7;
    localparam logic [OPC_W-1:0] BEQ   = 4'd8;
    localparam logic [OPC_W-1:0] BNE   = 4'd9;

    // Requester ids
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Output register FSM: EMPTY means full=0, HELD means full=1
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HELD  = 1'b1;

    // Everything the ALU produces for one operation
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              branch;
    } alu_out_t;

    // The port that should win the next tie after `p` was served
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 8-bit ALU shared by both issue ports. Purely combinational.
module alu
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0]         opcode,
    input  logic                     dir,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result,
    output logic                     zero,
    output logic                     branch_taken
);

    logic [DATA_W-1:0] a_u;
    logic [DATA_W-1:0] b_u;
    logic              known_op;

    assign a_u = a;
    assign b_u = b;

    // Decode the opcode; unknown opcodes force result 0 and zero=1
    always_comb begin
        result       = '0;
        branch_taken = 1'b0;
        known_op     = 1'b1;
        case (opcode)
            ADD, ADDI: result = a + b;
            SUB:       result = a - b;
            AND:       result = a & b;
            OR:        result = a | b;
            XOR:       result = a ^ b;
            SLT:       result = {{(DATA_W-1){1'b0}}, (a < b)};
            SHIFT: begin
                // b is a shift amount read as unsigned; anything >= 8 clears
                if (b_u[DATA_W-1:3] != '0) begin
                    result = '0;
                end else if (dir) begin
                    result = a_u >> b_u[2:0];
                end else begin
                    result = a_u << b_u[2:0];
                end
            end
            BEQ: begin
                result       = a - b;
                branch_taken = (a == b);
            end
            BNE: begin
                result       = a - b;
                branch_taken = (a != b);
            end
            default: known_op = 1'b0;
        endcase
        zero = known_op ? (result == '0) : 1'b1;
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to prio.
module rr_arb2
    import alu_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic grant0,
    output logic grant1
);

    // At most one grant; the priority pointer only matters on a tie
    always_comb begin
        grant0 = valid0 && (!valid1 || (prio == PORT0));
        grant1 = valid1 && (!valid0 || (prio == PORT1));
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two issue ports. A round-robin grant picks the
// operation, the ALU evaluates it in the same cycle and the result lands
// in a single output register returned to the originating port one cycle
// later.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A requester keeps valid high and its fields stable until ready;
// ready may depend combinationally on valid and on the response side.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic              req0_dir,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic              req1_dir,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_branch,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_branch,

    output logic [0:0]        dbg_state
);

    // Output register and priority pointer
    logic [0:0]        state_q,  state_d;
    logic              owner_q,  owner_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q,   zero_d;
    logic              branch_q, branch_d;
    logic              prio_q,   prio_d;

    logic              full;
    logic              rsp_hs;
    logic              slot_free;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              gsel;

    logic [OPC_W-1:0]  alu_opcode;
    logic              alu_dir;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    alu_out_t          alu_out;

    assign full      = (state_q == HELD);
    assign dbg_state = state_q;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .prio   (prio_q),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    alu u_alu (
        .opcode       (alu_opcode),
        .dir          (alu_dir),
        .a            (alu_a),
        .b            (alu_b),
        .result       (alu_out.result),
        .zero         (alu_out.zero),
        .branch_taken (alu_out.branch)
    );

    // Response side: only the owner sees valid; reset masks everything so
    // a held result is never presented while rst is high
    always_comb begin
        rsp0_valid  = full && (owner_q == PORT0) && !rst;
        rsp1_valid  = full && (owner_q == PORT1) && !rst;
        rsp0_result = result_q;
        rsp0_zero   = zero_q;
        rsp0_branch = branch_q;
        rsp1_result = result_q;
        rsp1_zero   = zero_q;
        rsp1_branch = branch_q;
        rsp_hs      = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    end

    // Request side: the register is free when empty or being drained now,
    // which is what allows a new grant in the same cycle as a response
    always_comb begin
        slot_free  = !full || rsp_hs;
        req0_ready = grant0 && slot_free && !rst;
        req1_ready = grant1 && slot_free && !rst;
        accept     = req0_ready || req1_ready;
        gsel       = req1_ready ? PORT1 : PORT0;
    end

    // Steer the granted port's operation into the shared ALU
    always_comb begin
        if (grant1) begin
            alu_opcode = req1_opcode;
            alu_dir    = req1_dir;
            alu_a      = req1_a;
            alu_b      = req1_b;
        end else begin
            alu_opcode = req0_opcode;
            alu_dir    = req0_dir;
            alu_a      = req0_a;
            alu_b      = req0_b;
        end
    end

    // Next-state: a grant loads the register and flips priority; a bare
    // response handshake empties it; otherwise everything holds
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        zero_d   = zero_q;
        branch_d = branch_q;
        prio_d   = prio_q;
        if (accept) begin
            state_d  = HELD;
            owner_d  = gsel;
            result_d = alu_out.result;
            zero_d   = alu_out.zero;
            branch_d = alu_out.branch;
            prio_d   = other_port(gsel);
        end else if (rsp_hs) begin
            state_d  = EMPTY;
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            owner_q  <= PORT0;
            result_q <= '0;
            zero_q   <= 1'b0;
            branch_q <= 1'b0;
            prio_q   <= FIRST_PRIO;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            branch_q <= branch_d;
            prio_q   <= prio_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, ties, contention, backpressure,
// ALU edge cases and reset while a result is held.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic              clk;
    logic              rst;
    logic              req0_valid, req0_ready, req0_dir;
    logic [3:0]        req0_opcode;
    logic [7:0]        req0_a, req0_b;
    logic              req1_valid, req1_ready, req1_dir;
    logic [3:0]        req1_opcode;
    logic [7:0]        req1_a, req1_b;
    logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_branch;
    logic [7:0]        rsp0_result;
    logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_branch;
    logic [7:0]        rsp1_result;
    logic [0:0]        dbg_state;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int n0;
    int n1;

    alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_dir    (req0_dir),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_dir    (req1_dir),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .rsp0_branch (rsp0_branch),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .rsp1_branch (rsp1_branch),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled at negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic d,
                          input logic [7:0] a, input logic [7:0] b);
        req0_valid = v; req0_opcode = op; req0_dir = d; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic d,
                          input logic [7:0] a, input logic [7:0] b);
        req1_valid = v; req1_opcode = op; req1_dir = d; req1_a = a; req1_b = b;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        drive1(1'b0, ADD, 1'b0, 8'd0, 8'd0);

        // ---- reset: nothing accepted, nothing presented
        @(negedge clk);
        drive0(1'b1, ADD, 1'b0, 8'd1, 8'd1);
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        step();
        rst = 1'b0;
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("rst_state", dbg_state, EMPTY);
        chk("rst_result", rsp0_result, 8'd0);
        chk("rst_zero", rsp0_zero, 1'b0);
        chk("rst_branch", rsp0_branch, 1'b0);

        // ---- tie after reset: port 0 first, then port 1
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, SUB, 1'b0, 8'd5, 8'd5);
        drive1(1'b1, SLT, 1'b0, 8'hFD, 8'd2);
        #1;
        chk("tie_req0_ready", req0_ready, 1'b1);
        chk("tie_req1_ready", req1_ready, 1'b0);
        step();
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("tie_rsp0_valid", rsp0_valid, 1'b1);
        chk("tie_rsp0_result", rsp0_result, 8'd0);
        chk("tie_rsp0_zero", rsp0_zero, 1'b1);
        chk("tie_rsp1_idle", rsp1_valid, 1'b0);
        chk("tie_state_held", dbg_state, HELD);
        chk("tie_req1_ready_next", req1_ready, 1'b1);
        step();
        drive1(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("tie_rsp1_valid", rsp1_valid, 1'b1);
        chk("tie_rsp1_result", rsp1_result, 8'd1);
        chk("tie_rsp1_zero", rsp1_zero, 1'b0);
        chk("tie_rsp0_gone", rsp0_valid, 1'b0);
        step();
        #1;
        chk("tie_drained", rsp1_valid, 1'b0);
        chk("tie_state_empty", dbg_state, EMPTY);

        // ---- single ADD on port 0 (prio now 0)
        drive0(1'b1, ADD, 1'b0, 8'd100, 8'd27);
        #1;
        chk("add_req0_ready", req0_ready, 1'b1);
        step();
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("add_rsp0_valid", rsp0_valid, 1'b1);
        chk("add_rsp0_result", rsp0_result, 8'd127);
        chk("add_rsp0_zero", rsp0_zero, 1'b0);
        chk("add_rsp1_idle", rsp1_valid, 1'b0);
        step();
        #1;
        chk("add_drained", rsp0_valid, 1'b0);

        // ---- sustained contention: prio is 1 after the port-0 ADD
        n0 = 0;
        n1 = 0;
        drive0(1'b1, ADD, 1'b0, 8'd1, 8'd10);
        drive1(1'b1, ADD, 1'b0, 8'd2, 8'd20);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_req0_ready", req0_ready, (k % 2) == 1);
            chk("rr_req1_ready", req1_ready, (k % 2) == 0);
            if (k > 0) begin
                if ((k % 2) == 1) begin
                    chk("rr_rsp1_valid", rsp1_valid, 1'b1);
                    chk("rr_rsp1_result", rsp1_result, 8'd22);
                end else begin
                    chk("rr_rsp0_valid", rsp0_valid, 1'b1);
                    chk("rr_rsp0_result", rsp0_result, 8'd11);
                end
            end
            n0 += int'(rsp0_valid);
            n1 += int'(rsp1_valid);
            step();
        end
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        drive1(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("rr_last_rsp0_valid", rsp0_valid, 1'b1);
        chk("rr_last_rsp0_result", rsp0_result, 8'd11);
        n0 += int'(rsp0_valid);
        n1 += int'(rsp1_valid);
        step();
        #1;
        chk("rr_drain0", rsp0_valid, 1'b0);
        chk("rr_drain1", rsp1_valid, 1'b0);
        chk("rr_count0", 8'(n0), 8'd4);
        chk("rr_count1", 8'(n1), 8'd4);

        // ---- backpressure on port 1 (prio now 1)
        rsp1_ready = 1'b0;
        drive1(1'b1, BNE, 1'b0, 8'd9, 8'd4);
        #1;
        chk("bp_req1_ready", req1_ready, 1'b1);
        step();
        drive1(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        drive0(1'b1, ADD, 1'b0, 8'd3, 8'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rsp1_valid", rsp1_valid, 1'b1);
            chk("bp_rsp1_result", rsp1_result, 8'd5);
            chk("bp_rsp1_branch", rsp1_branch, 1'b1);
            chk("bp_req0_stalled", req0_ready, 1'b0);
            chk("bp_rsp0_idle", rsp0_valid, 1'b0);
            step();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", req0_ready, 1'b1);
        chk("bp_release_rsp1_valid", rsp1_valid, 1'b1);
        step();
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("bp_rsp0_valid", rsp0_valid, 1'b1);
        chk("bp_rsp0_result", rsp0_result, 8'd7);
        chk("bp_rsp1_gone", rsp1_valid, 1'b0);
        step();

        // ---- ALU edges, issued back to back on port 0
        drive0(1'b1, SHIFT, 1'b0, 8'd1, 8'd9);
        #1;
        chk("sh_req0_ready", req0_ready, 1'b1);
        step();
        drive0(1'b1, ADD, 1'b0, 8'd127, 8'd1);
        #1;
        chk("sh9_result", rsp0_result, 8'd0);
        chk("sh9_zero", rsp0_zero, 1'b1);
        chk("b2b_req0_ready", req0_ready, 1'b1);
        step();
        drive0(1'b1, SHIFT, 1'b1, 8'h80, 8'd3);
        #1;
        chk("wrap_result", rsp0_result, 8'h80);
        chk("wrap_zero", rsp0_zero, 1'b0);
        step();
        drive0(1'b1, XOR, 1'b0, 8'hF0, 8'h3C);
        #1;
        chk("shr_result", rsp0_result, 8'h10);
        step();
        drive0(1'b1, 4'hF, 1'b0, 8'd5, 8'd6);
        #1;
        chk("xor_result", rsp0_result, 8'hCC);
        step();
        drive0(1'b1, BEQ, 1'b0, 8'd7, 8'd7);
        #1;
        chk("undef_result", rsp0_result, 8'd0);
        chk("undef_zero", rsp0_zero, 1'b1);
        chk("undef_branch", rsp0_branch, 1'b0);
        step();
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("beq_result", rsp0_result, 8'd0);
        chk("beq_zero", rsp0_zero, 1'b1);
        chk("beq_branch", rsp0_branch, 1'b1);
        step();

        // ---- reset while a port-0 result is held (prio then points at 1)
        rsp0_ready = 1'b0;
        drive0(1'b1, ADD, 1'b0, 8'd10, 8'd20);
        #1;
        chk("mr_req0_ready", req0_ready, 1'b1);
        step();
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("mr_held_valid", rsp0_valid, 1'b1);
        chk("mr_held_result", rsp0_result, 8'd30);
        rst = 1'b1;
        drive0(1'b1, ADD, 1'b0, 8'd1, 8'd1);
        #1;
        chk("mr_rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("mr_rst_req0_ready", req0_ready, 1'b0);
        step();
        rst = 1'b0;
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("mr_after_valid", rsp0_valid, 1'b0);
        chk("mr_after_state", dbg_state, EMPTY);
        chk("mr_after_result", rsp0_result, 8'd0);
        step();
        #1;
        chk("mr_never_back", rsp0_valid, 1'b0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, ADD, 1'b0, 8'd1, 8'd2);
        drive1(1'b1, ADD, 1'b0, 8'd3, 8'd4);
        #1;
        chk("mr_tie_req0_ready", req0_ready, 1'b1);
        chk("mr_tie_req1_ready", req1_ready, 1'b0);
        step();
        drive0(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("mr_tie_rsp0_result", rsp0_result, 8'd3);
        chk("mr_tie_req1_next", req1_ready, 1'b1);
        step();
        drive1(1'b0, ADD, 1'b0, 8'd0, 8'd0);
        #1;
        chk("mr_tie_rsp1_valid", rsp1_valid, 1'b1);
        chk("mr_tie_rsp1_result", rsp1_result, 8'd7);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
